// File: rtl/voting_pkg.sv
// +----------------------------------------------------------------------+
// | voting_pkg : shared state encoding and default sizing for the ballot |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package voting_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_PRESS    = 2'd2,
    ST_WAIT_REL = 2'd3
  } vote_state_e;

  localparam int DEF_NUM_CAND    = 4;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_HOLD_CYCLES = 10;
  // Wide enough for the largest legal hold requirement.
  localparam int HOLD_W          = 16;

endpackage

`default_nettype wire

// File: rtl/vote_max_finder.sv
// +----------------------------------------------------------------------+
// | vote_max_finder : combinational leader / tie detection over counts   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module vote_max_finder import voting_pkg::*; #(
  parameter int NUM_CAND = DEF_NUM_CAND,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int IDX_W    = $clog2(NUM_CAND)
) (
  input  logic [NUM_CAND-1:0][CNT_W-1:0] counts_i,
  output logic [IDX_W-1:0]               winner_o,
  output logic                           tie_o
);

  logic [CNT_W-1:0] max_v;
  logic [4:0]       n_max;

  // Strict '>' keeps the lowest index when several candidates share the max.
  always_comb begin
    max_v    = counts_i[0];
    winner_o = '0;
    for (int i = 1; i < NUM_CAND; i++) begin
      if (counts_i[i] > max_v) begin
        max_v    = counts_i[i];
        winner_o = IDX_W'(i);
      end
    end
    n_max = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (counts_i[i] == max_v) begin
        n_max = n_max + 5'd1;
      end
    end
    tie_o = (max_v != '0) && (n_max > 5'd1);
  end

endmodule

`default_nettype wire

// File: rtl/voting_machine_n.sv
// +----------------------------------------------------------------------+
// | voting_machine_n : armed, debounced single-vote ballot with tallies  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module voting_machine_n import voting_pkg::*; #(
  parameter int NUM_CAND    = DEF_NUM_CAND,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        mode,
  input  logic                        arm,
  input  logic [NUM_CAND-1:0]         button,
  output logic [CNT_W-1:0]            led,
  output logic                        armed,
  output logic                        vote_ack,
  output logic                        multi_press,
  output logic [$clog2(NUM_CAND)-1:0] winner,
  output logic                        tie
);

  localparam int                IDX_W    = $clog2(NUM_CAND);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [HOLD_W-1:0] HOLD_TGT = HOLD_W'(HOLD_CYCLES);

  vote_state_e                   state_q;
  logic                          arm_q;
  logic [HOLD_W-1:0]             hold_q;
  logic [HOLD_W-1:0]             hold_d;
  logic [IDX_W-1:0]              sel_q;
  logic [NUM_CAND-1:0][CNT_W-1:0] counts_q;
  logic [CNT_W-1:0]              led_q;
  logic                          vote_ack_q;
  logic                          multi_q;
  logic [IDX_W-1:0]              winner_q;
  logic                          tie_q;

  logic [IDX_W-1:0]              first_idx;
  logic                          one_hot;
  logic [NUM_CAND-1:0]           sel_mask;
  logic [NUM_CAND-1:0]           others;
  logic [IDX_W-1:0]              max_idx;
  logic                          max_tie;

  always_comb begin
    first_idx = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (button[i]) begin
        first_idx = IDX_W'(i);
      end
    end
  end

  assign one_hot  = (button != '0) && ((button & (button - NUM_CAND'(1))) == '0);
  assign sel_mask = NUM_CAND'(1) << sel_q;
  assign others   = button & ~sel_mask;
  assign hold_d   = hold_q + HOLD_W'(1);

  vote_max_finder #(
    .NUM_CAND (NUM_CAND),
    .CNT_W    (CNT_W),
    .IDX_W    (IDX_W)
  ) u_max (
    .counts_i (counts_q),
    .winner_o (max_idx),
    .tie_o    (max_tie)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      arm_q      <= 1'b0;
      hold_q     <= '0;
      sel_q      <= '0;
      counts_q   <= '0;
      led_q      <= '0;
      vote_ack_q <= 1'b0;
      multi_q    <= 1'b0;
      winner_q   <= '0;
      tie_q      <= 1'b0;
    end else begin
      vote_ack_q <= 1'b0;
      multi_q    <= 1'b0;
      winner_q   <= max_idx;
      tie_q      <= max_tie;
      led_q      <= (mode && (button != '0)) ? counts_q[first_idx] : '0;

      // Display mode aborts any ballot in progress and drops the authorisation.
      if (mode) begin
        state_q <= ST_IDLE;
        arm_q   <= 1'b0;
        hold_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (arm) begin
              state_q <= ST_ARMED;
              arm_q   <= 1'b1;
            end
          end
          ST_ARMED: begin
            if (one_hot) begin
              sel_q   <= first_idx;
              hold_q  <= HOLD_W'(1);
              state_q <= ST_PRESS;
            end else if (button != '0) begin
              multi_q <= 1'b1;
              state_q <= ST_WAIT_REL;
            end
          end
          ST_PRESS: begin
            if (others != '0) begin
              multi_q <= 1'b1;
              hold_q  <= '0;
              state_q <= ST_WAIT_REL;
            end else if (!button[sel_q]) begin
              hold_q  <= '0;
              state_q <= ST_ARMED;
            end else if (hold_d == HOLD_TGT) begin
              if (counts_q[sel_q] != CNT_MAX) begin
                counts_q[sel_q] <= counts_q[sel_q] + CNT_W'(1);
              end
              vote_ack_q <= 1'b1;
              arm_q      <= 1'b0;
              hold_q     <= '0;
              state_q    <= ST_WAIT_REL;
            end else begin
              hold_q <= hold_d;
            end
          end
          ST_WAIT_REL: begin
            if (button == '0) begin
              state_q <= arm_q ? ST_ARMED : ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // The arm flag is only ever set while outside IDLE, so it is the armed indication.
  assign armed       = arm_q;
  assign led         = led_q;
  assign vote_ack    = vote_ack_q;
  assign multi_press = multi_q;
  assign winner      = winner_q;
  assign tie         = tie_q;

endmodule

`default_nettype wire

// File: tb/tb_voting_machine_n.sv
// +----------------------------------------------------------------------+
// | tb_voting_machine_n : directed vector table plus corner sequences    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_voting_machine_n;

  logic       clock;
  logic       reset_n;
  logic       mode;
  logic       arm;
  logic [3:0] button;
  logic [7:0] led;
  logic       armed;
  logic       vote_ack;
  logic       multi_press;
  logic [1:0] winner;
  logic       tie;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       mode;
    logic       arm;
    logic [3:0] btn;
    logic       armed;
    logic       ack;
    logic       multi;
    logic [7:0] led;
    logic [1:0] winner;
    logic       tie;
  } vec_t;

  vec_t vq[$];

  voting_machine_n #(
    .NUM_CAND    (4),
    .CNT_W       (8),
    .HOLD_CYCLES (4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .mode        (mode),
    .arm         (arm),
    .button      (button),
    .led         (led),
    .armed       (armed),
    .vote_ack    (vote_ack),
    .multi_press (multi_press),
    .winner      (winner),
    .tie         (tie)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0d exp=%0d", name, idx, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic addv(input logic m, input logic a, input logic [3:0] b,
                      input logic ar, input logic ak, input logic mu,
                      input logic [7:0] l, input logic [1:0] w, input logic t);
    vec_t v;
    v.mode = m; v.arm = a; v.btn = b; v.armed = ar; v.ack = ak;
    v.multi = mu; v.led = l; v.winner = w; v.tie = t;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    mode = 1'b0; arm = 1'b0; button = 4'b0000;
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic vote(input int idx, input int tag);
    arm = 1'b1;
    step();
    arm = 1'b0;
    button = 4'(1 << idx);
    step(); step(); step();
    step();
    chk("vote_ack", tag, 32'(vote_ack), 32'd1);
    button = 4'b0000;
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    mode = 1'b0; arm = 1'b0; button = 4'b0000;
    @(posedge clock); @(posedge clock); #1;
    chk("rst_armed",  0, 32'(armed),       32'd0);
    chk("rst_ack",    0, 32'(vote_ack),    32'd0);
    chk("rst_multi",  0, 32'(multi_press), 32'd0);
    chk("rst_led",    0, 32'(led),         32'd0);
    chk("rst_winner", 0, 32'(winner),      32'd0);
    chk("rst_tie",    0, 32'(tie),         32'd0);
    reset_n = 1'b1;
    step();

    // mode arm btn | armed ack multi led winner tie (outputs after the edge)
    addv(0, 1, 4'b0000, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) addv(0, 0, 4'b0010, 1, 0, 0, 0, 0, 0);
    addv(0, 0, 4'b0010, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) addv(0, 0, 4'b0010, 0, 0, 0, 0, 1, 0);
    addv(0, 0, 4'b0000, 0, 0, 0, 0, 1, 0);
    addv(0, 1, 4'b0000, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) addv(0, 0, 4'b0100, 1, 0, 0, 0, 1, 0);
    addv(0, 0, 4'b0000, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) addv(0, 0, 4'b0100, 1, 0, 0, 0, 1, 0);
    addv(0, 0, 4'b0100, 0, 1, 0, 0, 1, 0);
    addv(0, 0, 4'b0000, 0, 0, 0, 0, 1, 1);
    addv(0, 1, 4'b0000, 1, 0, 0, 0, 1, 1);
    addv(0, 0, 4'b1001, 1, 0, 1, 0, 1, 1);
    addv(0, 0, 4'b1001, 1, 0, 0, 0, 1, 1);
    addv(0, 0, 4'b0000, 1, 0, 0, 0, 1, 1);
    addv(1, 0, 4'b0100, 0, 0, 0, 1, 1, 1);
    addv(1, 0, 4'b0110, 0, 0, 0, 1, 1, 1);
    addv(0, 0, 4'b0000, 0, 0, 0, 0, 1, 1);
    addv(1, 1, 4'b0000, 0, 0, 0, 0, 1, 1);
    addv(0, 0, 4'b0000, 0, 0, 0, 0, 1, 1);
    addv(0, 1, 4'b0000, 1, 0, 0, 0, 1, 1);
    addv(0, 0, 4'b0001, 1, 0, 0, 0, 1, 1);
    addv(0, 0, 4'b0001, 1, 0, 0, 0, 1, 1);
    addv(0, 0, 4'b0011, 1, 0, 1, 0, 1, 1);
    addv(0, 0, 4'b0000, 1, 0, 0, 0, 1, 1);
    addv(0, 0, 4'b0001, 1, 0, 0, 0, 1, 1);
    addv(1, 0, 4'b0001, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) addv(0, 0, 4'b0001, 0, 0, 0, 0, 1, 1);

    foreach (vq[i]) begin
      mode = vq[i].mode; arm = vq[i].arm; button = vq[i].btn;
      step();
      chk("v_armed",  i, 32'(armed),       32'(vq[i].armed));
      chk("v_ack",    i, 32'(vote_ack),    32'(vq[i].ack));
      chk("v_multi",  i, 32'(multi_press), 32'(vq[i].multi));
      chk("v_led",    i, 32'(led),         32'(vq[i].led));
      chk("v_winner", i, 32'(winner),      32'(vq[i].winner));
      chk("v_tie",    i, 32'(tie),         32'(vq[i].tie));
    end

    // Leader, tie break and display latency.
    do_reset();
    vote(0, 100); vote(0, 101); vote(2, 102); vote(2, 103);
    step();
    chk("tie_winner", 0, 32'(winner), 32'd0);
    chk("tie_flag",   0, 32'(tie),    32'd1);
    vote(2, 104);
    step();
    chk("lead_winner", 0, 32'(winner), 32'd2);
    chk("lead_tie",    0, 32'(tie),    32'd0);
    mode = 1'b1; button = 4'b0100;
    step();
    chk("disp_led", 2, 32'(led), 32'd3);
    mode = 1'b0; button = 4'b0000;
    step();
    chk("disp_off", 2, 32'(led), 32'd0);

    // Saturation at the counter ceiling.
    do_reset();
    for (int i = 0; i < 255; i++) vote(3, 1000 + i);
    mode = 1'b1; button = 4'b1000;
    step();
    chk("sat_pre_led", 3, 32'(led), 32'd255);
    mode = 1'b0; button = 4'b0000;
    step();
    vote(3, 2000);
    mode = 1'b1; button = 4'b1000;
    step();
    chk("sat_led",    3, 32'(led),    32'd255);
    chk("sat_winner", 3, 32'(winner), 32'd3);
    mode = 1'b0; button = 4'b0000;
    step();

    // Reset in the middle of a press.
    arm = 1'b1;
    step();
    arm = 1'b0; button = 4'b0001;
    step(); step();
    chk("mid_armed",  0, 32'(armed),  32'd1);
    chk("mid_winner", 0, 32'(winner), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_armed",  0, 32'(armed),       32'd0);
    chk("arst_ack",    0, 32'(vote_ack),    32'd0);
    chk("arst_multi",  0, 32'(multi_press), 32'd0);
    chk("arst_led",    0, 32'(led),         32'd0);
    chk("arst_winner", 0, 32'(winner),      32'd0);
    chk("arst_tie",    0, 32'(tie),         32'd0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_ack",   i, 32'(vote_ack), 32'd0);
      chk("post_armed", i, 32'(armed),    32'd0);
    end
    button = 4'b0000;
    step();
    vote(0, 3000);
    mode = 1'b1; button = 4'b0001;
    step();
    chk("post_led0", 0, 32'(led), 32'd1);
    button = 4'b1000;
    step();
    chk("post_led3", 3, 32'(led), 32'd0);
    mode = 1'b0; button = 4'b0000;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/voting_machine_n.md
VOTING_MACHINE_N -- requirements
Module: voting_machine_n

Interface
REQ-001 The block SHALL have parameter NUM_CAND, default 4, giving the number of candidates; the legal range SHALL be 2..16.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the per-candidate vote counter width and the led width.
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 10, giving the consecutive sampled-high cycles required for a valid press; the legal range SHALL be 2..2^16-1.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = voting, 1 = result display.
REQ-007 The block SHALL have port arm, input, 1 bit: the poll-worker enable, which authorises exactly one vote.
REQ-008 The block SHALL have port button, input, NUM_CAND bits: candidate buttons, bit i = candidate i.
REQ-009 The block SHALL have port led, output, CNT_W bits: the result display.
REQ-010 The block SHALL have port armed, output, 1 bit: high while a vote is authorised and not yet consumed.
REQ-011 The block SHALL have port vote_ack, output, 1 bit: a one-cycle pulse when a vote is accepted.
REQ-012 The block SHALL have port multi_press, output, 1 bit: a one-cycle pulse when a press is rejected because more than one button is high.
REQ-013 The block SHALL have port winner, output, $clog2(NUM_CAND) bits: index of the candidate with the highest count.
REQ-014 The block SHALL have port tie, output, 1 bit: high when two or more candidates share a nonzero maximum count.

Function
REQ-015 The FSM SHALL have states IDLE, ARMED, PRESS and WAIT_REL, plus a held-arm flag.
REQ-016 In IDLE with mode=0 and arm=1, the FSM SHALL go to ARMED; arm SHALL be ignored in every other state and whenever mode=1.
REQ-017 In ARMED, exactly one button high SHALL latch its index, set hold=1 and go to PRESS; more than one button high SHALL pulse multi_press and go to WAIT_REL with the arm kept.
REQ-018 In PRESS, while the latched button alone is high, hold SHALL increment on each edge.
REQ-019 On the edge where hold reaches HOLD_CYCLES, the block SHALL increment that candidate's count, assert vote_ack for the following cycle, consume the arm and go to WAIT_REL.
REQ-020 In PRESS, release of the latched button before HOLD_CYCLES SHALL clear hold and return to ARMED with no count change.
REQ-021 In PRESS, any additional button rising SHALL pulse multi_press, clear hold and go to WAIT_REL with the arm kept.
REQ-022 WAIT_REL SHALL stay until all buttons are low, then go to ARMED if the arm is kept, else to IDLE.
REQ-023 armed SHALL be high in ARMED, in PRESS, and in WAIT_REL with the arm kept.
REQ-024 A count at 2^CNT_W-1 SHALL saturate (remain unchanged) while vote_ack still pulses.
REQ-025 mode=1 in any state SHALL force IDLE on the next edge, discarding the arm and any partial press, with no count change.
REQ-026 led SHALL be registered (1-cycle latency): with mode=1 it SHALL show the count of the lowest-index high button, or 0 if no button is high; with mode=0 it SHALL be 0.
REQ-027 winner and tie SHALL be registered from the counts of the previous cycle; ties SHALL resolve winner to the lowest index; all counts zero SHALL give winner=0, tie=0.

Reset
REQ-028 While reset_n=0, all counts, hold, the arm flag, led, vote_ack, multi_press, winner and tie SHALL be 0, the state SHALL be IDLE, and armed SHALL be 0.
REQ-029 Reset asserted mid-press SHALL discard the press with no count change; after release, no vote SHALL occur until a new arm.

Structure
REQ-030 The state enum and the default parameter constants SHALL live in package voting_pkg.
REQ-031 The max/tie reduction over NUM_CAND counts SHALL be the sub-module vote_max_finder, which is combinational and whose outputs are registered in the parent.

Verification (NUM_CAND=4, CNT_W=8, HOLD_CYCLES=4)
REQ-032 Arm, then button[1] held 4 cycles -> one vote_ack, count1=1, armed=0; holding it 10 further cycles -> no second vote.
REQ-033 Arm, then button[2] held 3 cycles and released -> no vote_ack, armed=1; then held 4 cycles -> count2=1.
REQ-034 Arm, then button[0] and button[3] rise together -> multi_press pulse, no count change, armed=1 after release.
REQ-035 Votes 0,0,2,2 -> winner=0, tie=1; then one vote for 2 -> winner=2, tie=0; mode=1 with button[2] -> led=3 one cycle later.
REQ-036 Preload count3=255 via 255 votes, then another vote for 3 -> vote_ack=1, count3 stays 255.
REQ-037 reset_n pulsed low at hold=2 -> all outputs 0; button still high after reset -> no vote until arm and a fresh 4-cycle press.
